// File: rtl/noc_pkg.sv
// Shared port indices and the destination-to-output routing rule for the
// three-port buffered switch.
package noc_pkg;

    typedef logic [1:0] port_t;

    localparam port_t TOP    = 2'd1;
    localparam port_t BOTTOM = 2'd2;
    localparam port_t LINK   = 2'd3;

    // Range compare on an already-extracted destination; the top range wins
    // where the two ranges overlap.
    function automatic port_t dest_port(input int d,
                                        input int top_min, input int top_max,
                                        input int bot_min, input int bot_max);
        if (d >= top_min && d <= top_max) return TOP;
        if (d >= bot_min && d <= bot_max) return BOTTOM;
        return LINK;
    endfunction

endpackage

// File: rtl/buffered_switch_if.sv
// Flit handshake bundle for all three switch ports; the slave view is the
// switch itself, the master view is whatever sits around it.
interface buffered_switch_if #(parameter int DataWidth = 32);

    logic [DataWidth-1:0] i_data1, i_data2, i_data3;
    logic                 i_data_valid1, i_data_valid2, i_data_valid3;
    logic                 o_data_ready1, o_data_ready2, o_data_ready3;
    logic [DataWidth-1:0] o_data1, o_data2, o_data3;
    logic                 o_data_valid1, o_data_valid2, o_data_valid3;
    logic                 i_data_ready1, i_data_ready2, i_data_ready3;

    modport slave (
        input  i_data1, i_data2, i_data3,
        input  i_data_valid1, i_data_valid2, i_data_valid3,
        output o_data_ready1, o_data_ready2, o_data_ready3,
        output o_data1, o_data2, o_data3,
        output o_data_valid1, o_data_valid2, o_data_valid3,
        input  i_data_ready1, i_data_ready2, i_data_ready3
    );

    modport master (
        output i_data1, i_data2, i_data3,
        output i_data_valid1, i_data_valid2, i_data_valid3,
        input  o_data_ready1, o_data_ready2, o_data_ready3,
        input  o_data1, o_data2, o_data3,
        input  o_data_valid1, o_data_valid2, o_data_valid3,
        output i_data_ready1, i_data_ready2, i_data_ready3
    );

endinterface

// File: rtl/noc_fifo.sv
// Per-input flit FIFO; pointers carry one extra wrap bit so full and empty
// come straight from registered state.
module noc_fifo #(
    parameter int DataWidth = 32,
    parameter int FifoDepth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DataWidth-1:0] wr_data,
    output logic                 full,
    input  logic                 rd_en,
    output logic [DataWidth-1:0] rd_data,
    output logic                 empty
);

    localparam int AW = $clog2(FifoDepth);

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [AW:0]          wptr, rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full) wptr <= wptr + 1'b1;
            if (rd_en && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/buffered_switch.sv
// Three-port input-buffered switch: per-input FIFOs, destination routing of
// each FIFO head, and a round-robin arbiter feeding a registered output.
module buffered_switch
    import noc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 4,
    parameter int FifoDepth = 4,
    parameter int bottomMin = 0,
    parameter int bottomMax = 0,
    parameter int topMin    = 1,
    parameter int topMax    = 1
) (
    input logic              i_clk,
    input logic              i_reset,
    buffered_switch_if.slave bus
);

    localparam int NumPorts = 3;

    logic [NumPorts-1:0][DataWidth-1:0] in_data, head, out_data;
    logic [NumPorts-1:0]                in_vld, in_rdy, full, empty, pop;
    logic [NumPorts-1:0]                out_vld, out_rdy, ld, any_req;
    logic [NumPorts-1:0][NumPorts-1:0]  req;   // [output][input]
    logic [NumPorts-1:0][1:0]           gnt, prio;
    port_t [NumPorts-1:0]               dst;
    logic [1:0]                         idx;

    assign in_data = {bus.i_data3, bus.i_data2, bus.i_data1};
    assign in_vld  = {bus.i_data_valid3, bus.i_data_valid2, bus.i_data_valid1};
    assign out_rdy = {bus.i_data_ready3, bus.i_data_ready2, bus.i_data_ready1};

    assign bus.o_data_ready1 = in_rdy[0];
    assign bus.o_data_ready2 = in_rdy[1];
    assign bus.o_data_ready3 = in_rdy[2];
    assign bus.o_data1       = out_data[0];
    assign bus.o_data2       = out_data[1];
    assign bus.o_data3       = out_data[2];
    assign bus.o_data_valid1 = out_vld[0];
    assign bus.o_data_valid2 = out_vld[1];
    assign bus.o_data_valid3 = out_vld[2];

    assign in_rdy = ~full;

    for (genvar i = 0; i < NumPorts; i++) begin : g_in
        noc_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) u_fifo (
            .clk    (i_clk),
            .rst    (i_reset),
            .wr_en  (in_vld[i] && in_rdy[i]),
            .wr_data(in_data[i]),
            .full   (full[i]),
            .rd_en  (pop[i]),
            .rd_data(head[i]),
            .empty  (empty[i])
        );
    end

    always_comb begin
        dst = '0;
        req = '0;
        for (int i = 0; i < NumPorts; i++) begin
            dst[i] = dest_port(int'(head[i][DataWidth-1 -: AddrWidth]),
                               topMin, topMax, bottomMin, bottomMax);
            for (int o = 0; o < NumPorts; o++)
                req[o][i] = !empty[i] && (dst[i] == 2'(o + 1));
        end
    end

    // An output register can take a new flit when empty or draining this cycle.
    assign ld = ~out_vld | out_rdy;

    // Walk from the priority input downward so the closest requester wins.
    always_comb begin
        gnt     = '0;
        any_req = '0;
        pop     = '0;
        idx     = '0;
        for (int o = 0; o < NumPorts; o++) begin
            for (int k = NumPorts - 1; k >= 0; k--) begin
                idx = 2'((int'(prio[o]) + k) % NumPorts);
                if (req[o][idx]) begin
                    gnt[o]     = idx;
                    any_req[o] = 1'b1;
                end
            end
            if (ld[o] && any_req[o]) pop[gnt[o]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_vld  <= '0;
            out_data <= '0;
            prio     <= '0;
        end else begin
            for (int o = 0; o < NumPorts; o++) begin
                if (ld[o]) begin
                    out_vld[o] <= any_req[o];
                    if (any_req[o]) begin
                        out_data[o] <= head[gnt[o]];
                        prio[o]     <= (gnt[o] == 2'd2) ? 2'd0 : gnt[o] + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_buffered_switch.sv
// Directed bench for buffered_switch: a queue-level model checked every cycle
// plus literal expectations for latency, ordering, back-pressure and reset.
module tb_buffered_switch;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int FD = 4;
    localparam int TOP_MIN = 1, TOP_MAX = 1, BOT_MIN = 0, BOT_MAX = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffered_switch_if #(.DataWidth(DW)) bus ();

    buffered_switch #(
        .DataWidth(DW), .AddrWidth(AW), .FifoDepth(FD),
        .bottomMin(BOT_MIN), .bottomMax(BOT_MAX),
        .topMin(TOP_MIN), .topMax(TOP_MAX)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    logic          tb_vld [3];
    logic [DW-1:0] tb_dat [3];
    logic          tb_rdy [3];
    logic          o_v [3];
    logic          o_r [3];
    logic [DW-1:0] o_d [3];

    assign bus.i_data1 = tb_dat[0];
    assign bus.i_data2 = tb_dat[1];
    assign bus.i_data3 = tb_dat[2];
    assign bus.i_data_valid1 = tb_vld[0];
    assign bus.i_data_valid2 = tb_vld[1];
    assign bus.i_data_valid3 = tb_vld[2];
    assign bus.i_data_ready1 = tb_rdy[0];
    assign bus.i_data_ready2 = tb_rdy[1];
    assign bus.i_data_ready3 = tb_rdy[2];
    assign o_v[0] = bus.o_data_valid1;
    assign o_v[1] = bus.o_data_valid2;
    assign o_v[2] = bus.o_data_valid3;
    assign o_r[0] = bus.o_data_ready1;
    assign o_r[1] = bus.o_data_ready2;
    assign o_r[2] = bus.o_data_ready3;
    assign o_d[0] = bus.o_data1;
    assign o_d[1] = bus.o_data2;
    assign o_d[2] = bus.o_data3;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Output index (0..2) a flit must leave on.
    function automatic int route(input logic [DW-1:0] f);
        int d;
        d = int'(f[DW-1 -: AW]);
        if (d >= TOP_MIN && d <= TOP_MAX) return 0;
        if (d >= BOT_MIN && d <= BOT_MAX) return 1;
        return 2;
    endfunction

    // ---------------- source driver ----------------
    logic [DW-1:0] src_q [3][$];
    int            acc_cyc [3][$];
    int            cyc = 0;
    logic          rdy_s [3];

    initial begin
        for (int p = 0; p < 3; p++) begin
            tb_vld[p] = 1'b0;
            tb_dat[p] = '0;
        end
        forever begin
            @(negedge clk); #1;
            for (int p = 0; p < 3; p++) begin
                tb_vld[p] = (src_q[p].size() > 0);
                tb_dat[p] = tb_vld[p] ? src_q[p][0] : '0;
                rdy_s[p]  = o_r[p];
            end
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 3; p++)
                if (!rst && tb_vld[p] && rdy_s[p]) begin
                    void'(src_q[p].pop_front());
                    acc_cyc[p].push_back(cyc);
                end
        end
    end

    // ---------------- output logger ----------------
    logic          ov_at [3][4096];
    logic [DW-1:0] od_at [3][4096];
    logic [DW-1:0] xfer_q [3][$];
    int            xfer_cyc [3][$];

    initial forever begin
        @(negedge clk); #4;
        if (cyc < 4096)
            for (int p = 0; p < 3; p++) begin
                ov_at[p][cyc] = o_v[p];
                od_at[p][cyc] = o_d[p];
            end
        if (!rst)
            for (int p = 0; p < 3; p++)
                if (o_v[p] && tb_rdy[p]) begin
                    xfer_q[p].push_back(o_d[p]);
                    xfer_cyc[p].push_back(cyc);
                end
    end

    // ---------------- queue-level model ----------------
    logic [DW-1:0] mq [3][$];
    logic          mv [3];
    logic [DW-1:0] md [3];
    int            last [3];

    task automatic model_step();
        int pick [3];
        bit can [3];
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                mq[p].delete();
                mv[p]   = 1'b0;
                md[p]   = '0;
                last[p] = 2;
            end
            return;
        end
        for (int p = 0; p < 3; p++) can[p] = (mq[p].size() < FD);
        for (int o = 0; o < 3; o++) begin
            pick[o] = -1;
            if (!mv[o] || tb_rdy[o]) begin
                for (int k = 1; k <= 3; k++) begin
                    int i;
                    i = (last[o] + k) % 3;
                    if (pick[o] < 0 && mq[i].size() > 0 && route(mq[i][0]) == o) pick[o] = i;
                end
                mv[o] = (pick[o] >= 0);
                if (pick[o] >= 0) begin
                    md[o]   = mq[pick[o]][0];
                    last[o] = pick[o];
                end
            end
        end
        for (int o = 0; o < 3; o++)
            if (pick[o] >= 0) void'(mq[pick[o]].pop_front());
        for (int p = 0; p < 3; p++)
            if (tb_vld[p] && can[p]) mq[p].push_back(tb_dat[p]);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst)
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("ready%0d", p + 1), {31'd0, o_r[p]}, {31'd0, mq[p].size() < FD});
                chk($sformatf("valid%0d", p + 1), {31'd0, o_v[p]}, {31'd0, mv[p]});
                if (mv[p]) chk($sformatf("data%0d", p + 1), o_d[p], md[p]);
            end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic wait_acc(input int p, input int n, input string nm);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (acc_cyc[p].size() < n && b < 60);
        #3;
        chk(nm, acc_cyc[p].size(), n);
    endtask

    task automatic wait_xfer(input int p, input int n, input string nm);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (xfer_q[p].size() < n && b < 100);
        #3;
        chk(nm, xfer_q[p].size(), n);
    endtask

    initial begin
        int a, b0, b1, xb, nacc, nx;
        for (int p = 0; p < 3; p++) tb_rdy[p] = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        for (int p = 0; p < 3; p++) begin
            chk("reset_valid", {31'd0, o_v[p]}, 32'd0);
            chk("reset_ready", {31'd0, o_r[p]}, 32'd1);
        end

        // Reset with three flits buffered behind a stalled bottom output.
        tb_rdy[1] = 1'b0;
        for (int k = 0; k < 3; k++) src_q[0].push_back(32'h0000_0100 + k);
        wait_acc(0, 3, "rst_fill_accepts");
        step(1);
        rst = 1'b1;
        for (int p = 0; p < 3; p++) src_q[p].delete();
        step(2);
        rst = 1'b0;
        step(1);
        for (int p = 0; p < 3; p++) begin
            chk("midrst_valid", {31'd0, o_v[p]}, 32'd0);
            chk("midrst_ready", {31'd0, o_r[p]}, 32'd1);
        end
        tb_rdy[1] = 1'b1;
        nx = xfer_q[0].size() + xfer_q[1].size() + xfer_q[2].size();
        step(6);
        chk("midrst_no_stale", xfer_q[0].size() + xfer_q[1].size() + xfer_q[2].size(), nx);

        // Bottom-to-top single flit: valid exactly one cycle, 2-edge latency.
        b1 = acc_cyc[1].size();
        src_q[1].push_back(32'h1000_00AA);
        wait_acc(1, b1 + 1, "lat_accept");
        a = acc_cyc[1][b1];
        step(3);
        chk("lat_not_early", {31'd0, ov_at[0][a]}, 32'd0);
        chk("lat_valid", {31'd0, ov_at[0][a + 1]}, 32'd1);
        chk("lat_data", od_at[0][a + 1], 32'h1000_00AA);
        chk("lat_one_cycle", {31'd0, ov_at[0][a + 2]}, 32'd0);

        // All inputs streaming to the link port: strict 1,2,3 rotation, full rate.
        xb = xfer_q[2].size();
        for (int s = 0; s < 6; s++)
            for (int p = 0; p < 3; p++)
                src_q[p].push_back(32'h7000_0000 | (32'(p + 1) << 8) | 32'(s));
        wait_xfer(2, xb + 18, "rr_count");
        for (int k = 0; k < 18; k++) begin
            chk("rr_order", xfer_q[2][xb + k], 32'h7000_0000 | (32'((k % 3) + 1) << 8) | 32'(k / 3));
            if (k > 0) chk("rr_rate", xfer_cyc[2][xb + k] - xfer_cyc[2][xb + k - 1], 32'd1);
        end

        // Back-pressure: bottom output stalled, top input fills then blocks.
        step(2);
        tb_rdy[1] = 1'b0;
        b0 = acc_cyc[0].size();
        xb = xfer_q[1].size();
        for (int k = 0; k < 6; k++) src_q[0].push_back(32'h0000_0010 + k);
        nacc = -1;
        for (int b = 0; b < 30 && nacc < 0; b++) begin
            @(negedge clk); #3;
            if (!o_r[0]) nacc = acc_cyc[0].size() - b0;
        end
        chk("bp_accepts_to_full", nacc, FD + 1);
        step(3);
        chk("bp_hold_valid", {31'd0, o_v[1]}, 32'd1);
        chk("bp_hold_data", o_d[1], 32'h0000_0010);
        chk("bp_ready_low", {31'd0, o_r[0]}, 32'd0);
        tb_rdy[1] = 1'b1;
        wait_xfer(1, xb + 6, "bp_count");
        for (int k = 0; k < 6; k++) chk("bp_order", xfer_q[1][xb + k], 32'h0000_0010 + k);

        // Crossing traffic top->bottom and bottom->top in the same cycle.
        step(2);
        b0 = acc_cyc[0].size();
        b1 = acc_cyc[1].size();
        src_q[0].push_back(32'h0000_0031);
        src_q[1].push_back(32'h1000_0032);
        wait_acc(0, b0 + 1, "cross_accept1");
        wait_acc(1, b1 + 1, "cross_accept2");
        a = acc_cyc[0][b0];
        step(3);
        chk("cross_bottom_valid", {31'd0, ov_at[1][a + 1]}, 32'd1);
        chk("cross_bottom_data", od_at[1][a + 1], 32'h0000_0031);
        chk("cross_top_valid", {31'd0, ov_at[0][a + 1]}, 32'd1);
        chk("cross_top_data", od_at[0][a + 1], 32'h1000_0032);

        // Loopback on the link port held until the sink is ready.
        tb_rdy[2] = 1'b0;
        xb = xfer_q[2].size();
        src_q[2].push_back(32'h3000_0033);
        step(6);
        chk("loop_hold_valid", {31'd0, o_v[2]}, 32'd1);
        chk("loop_hold_data", o_d[2], 32'h3000_0033);
        tb_rdy[2] = 1'b1;
        step(3);
        chk("loop_once", xfer_q[2].size() - xb, 32'd1);
        chk("loop_data", xfer_q[2][xb], 32'h3000_0033);
        chk("loop_drained", {31'd0, o_v[2]}, 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/buffered_switch.md
BUFFERED_SWITCH -- requirements
Module: buffered_switch

Interface
REQ-001 SHALL have parameter DataWidth, default 32, flit width in bits.
REQ-002 SHALL have parameter AddrWidth, default 4, destination-field width taken from flit MSBs [DataWidth-1 -: AddrWidth].
REQ-003 SHALL have parameter FifoDepth, default 4, per-input FIFO entries (power of two, >=2).
REQ-004 SHALL have parameters bottomMin, bottomMax, default 0, 0, inclusive destination range routed to port 2.
REQ-005 SHALL have parameters topMin, topMax, default 1, 1, inclusive destination range routed to port 1.
REQ-006 SHALL have port i_clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have, for n in {1 (top), 2 (bottom), 3 (link)}: i_data<n> input DataWidth; i_data_valid<n> input 1; o_data_ready<n> output 1; o_data<n> output DataWidth; o_data_valid<n> output 1; i_data_ready<n> input 1.

Function
REQ-009 SHALL accept an input flit on any edge where i_data_valid<n> and o_data_ready<n> are both high, writing it to input FIFO n.
REQ-010 SHALL drive o_data_ready<n> = not full(FIFO n), with no combinational dependence on any i_data_ready.
REQ-011 SHALL route each FIFO head by destination d: topMin<=d<=topMax -> port 1; else bottomMin<=d<=bottomMax -> port 2; else -> port 3; the top range wins on overlap.
REQ-012 SHALL route by destination only, including loopback to the arrival port.
REQ-013 SHALL give each output port a round-robin arbiter over requesting FIFO heads, in order 1,2,3, with priority moving to the input after the granted one.
REQ-014 SHALL hold each output in a register; o_data<n> and o_data_valid<n> SHALL stay stable while o_data_valid<n>=1 and i_data_ready<n>=0.
REQ-015 SHALL load an output register, and pop the granted FIFO on the same edge, when that register is empty or being accepted that cycle, giving one flit per cycle per output at full rate.
REQ-016 SHALL have 2-cycle uncontended latency: a flit accepted at edge t is valid on its output after edge t+1.
REQ-017 SHALL grant each input at most once per cycle; heads to distinct outputs SHALL proceed in parallel.
REQ-018 SHALL preserve order of flits from one input to one output.
REQ-019 SHALL block a full FIFO (ready low) with no data loss or overwrite; a blocked head SHALL stall only its own FIFO.
REQ-020 SHALL allow FIFO read and write on the same edge, including when full (pop frees the slot only on the next cycle, since ready is computed from the registered full flag).
REQ-021 SHALL wrap FIFO read/write pointers modulo FifoDepth, with full/empty from an extra pointer bit.

Reset
REQ-022 SHALL, on i_reset high, asynchronously clear all FIFOs to empty, all o_data_valid<n> to 0, all o_data<n> to 0, and set every arbiter priority to input 1.
REQ-023 SHALL drive o_data_ready<n>=1 from the first edge after reset deasserts.
REQ-024 SHALL discard any in-flight or buffered flit when reset asserts mid-transfer.

Structure
REQ-025 SHALL place port-index constants (TOP=1, BOTTOM=2, LINK=3) and the destination-extract/range-compare function in shared package noc_pkg.
REQ-026 SHALL instantiate one sub-module, noc_fifo (DataWidth, FifoDepth), once per input; the arbiters and output registers SHALL be inline.

Verification (DataWidth=32, AddrWidth=4, top=1..1, bottom=0..0)
REQ-027 SHALL check: reset mid-stream with 3 flits buffered -> all valids 0, all readies 1 after release, no stale flit emitted.
REQ-028 SHALL check: port 2 sends 0x1000_00AA at edge t with all readies high -> o_data1=0x1000_00AA, o_data_valid1 high after edge t+1, valid for one cycle.
REQ-029 SHALL check: ports 1,2,3 each stream flits with d=7 continuously -> o_data3 order 1,2,3,1,2,3..., one flit per cycle.
REQ-030 SHALL check: i_data_ready2 held low, port 1 sends 6 flits with d=0 -> o_data_ready1 falls after FifoDepth+1 accepts, data held stable, all 6 delivered in order after release.
REQ-031 SHALL check: port 1 sends d=0 and port 2 sends d=1 on the same edge -> both delivered on the same cycle (crossing, no contention).
REQ-032 SHALL check: port 3 sends d=3 with port 3's i_data_ready low -> loopback flit held on o_data3 until ready rises, then consumed exactly once.
